// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage IF/ID/EX/MEM/WB pipeline.
// Keeps a shadow scoreboard of the EX, MEM and WB instructions. From it and
// the ID instruction fields it derives stall/bubble, the taken-branch
// flushes, the EX operand forwarding selects and two saturating counters.
//
//   state | meaning
//   RUN   | normal issue, no hazard seen last cycle
//   HOLD  | ID held for a RAW / load-use hazard, bubble going into EX
//   FLUSH | cycle after a taken-branch flush; younger entries are empty
module pipe_hazard_ctrl #(
   parameter bit FORWARD_EN = 1'b1,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_wr,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_load,
   input  logic              id_branch,
   input  logic              mem_cond,
   output logic              pc_stall,
   output logic              id_ex_bubble,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              flush_ex_mem,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef struct packed {
      logic              valid;
      logic              wr;
      logic [REG_AW-1:0] rd;
      logic              load;
      logic              branch;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic              use1;
      logic              use2;
   } entry_t;

   typedef enum logic [1:0] {RUN = 2'd0, HOLD = 2'd1, FLUSH = 2'd2} state_t;

   entry_t ex_e, mem_e, wb_e, id_e;
   state_t state;
   logic   use1, use2;
   logic   m_ex, m_mem, m_wb;
   logic   hazard, taken, stall;

   // An entry produces r for a consumer that actually reads it; r0 never counts.
   function automatic logic hits(input entry_t e, input logic [REG_AW-1:0] r, input logic u);
      return e.valid && e.wr && (e.rd == r) && (r != '0) && u;
   endfunction

   // Operand select for one EX source; MEM result is newer than WB so it wins.
   // Loads in MEM have no data yet, so only WB may supply a load result.
   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] r, input logic u);
      logic [1:0] sel;
      sel = 2'b00;
      if (FORWARD_EN && ex_e.valid && u && (r != '0)) begin
         if (mem_e.valid && mem_e.wr && !mem_e.load && (mem_e.rd == r))
            sel = 2'b01;
         else if (wb_e.valid && wb_e.wr && (wb_e.rd == r))
            sel = 2'b10;
      end
      return sel;
   endfunction

   // ID instruction packed as a scoreboard entry, plus hazard/branch decode.
   always_comb begin
      id_e   = {id_valid, id_wr, id_rd, id_load, id_branch,
                id_rs1, id_rs2, id_use_rs1, id_use_rs2};
      use1   = id_valid && id_use_rs1;
      use2   = id_valid && id_use_rs2;
      m_ex   = hits(ex_e,  id_rs1, use1) || hits(ex_e,  id_rs2, use2);
      m_mem  = hits(mem_e, id_rs1, use1) || hits(mem_e, id_rs2, use2);
      m_wb   = hits(wb_e,  id_rs1, use1) || hits(wb_e,  id_rs2, use2);
      // The WB write lands on the same edge ID/EX captures, so the regfile
      // read in ID is stale and must wait one cycle even with forwarding.
      if (FORWARD_EN)
         hazard = (m_ex && ex_e.load) || m_wb;
      else
         hazard = m_ex || m_mem || m_wb;
      taken  = mem_e.valid && mem_e.branch && mem_cond;
      stall  = hazard && !taken;
   end

   // Control outputs are combinational from the scoreboard and ID fields.
   always_comb begin
      pc_stall     = stall;
      id_ex_bubble = stall;
      flush_if_id  = taken;
      flush_id_ex  = taken;
      flush_ex_mem = taken;
      fwd_a        = fwd_sel(ex_e.rs1, ex_e.use1);
      fwd_b        = fwd_sel(ex_e.rs2, ex_e.use2);
   end

   // Scoreboard shift, sequencing FSM and saturating counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_e      <= '0;
         mem_e     <= '0;
         wb_e      <= '0;
         state     <= RUN;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         wb_e  <= mem_e;
         mem_e <= taken ? '0 : ex_e;
         ex_e  <= (taken || stall) ? '0 : id_e;

         case (state)
            RUN:     state <= taken ? FLUSH : (hazard ? HOLD : RUN);
            HOLD:    state <= taken ? FLUSH : (hazard ? HOLD : RUN);
            FLUSH:   state <= RUN;
            default: state <= RUN;
         endcase

         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (taken && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   // Fields carried for visibility in the scoreboard but not consumed here.
   logic unused_fields;
   assign unused_fields = ^{wb_e.rs1, wb_e.rs2, wb_e.use1, wb_e.use2, wb_e.load,
                            wb_e.branch, mem_e.rs1, mem_e.rs2, mem_e.use1,
                            mem_e.use2, ex_e.branch};

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: one instance with forwarding (16-bit counters)
// and one without forwarding (4-bit counters so saturation is reachable).
// Both see the same ID stimulus; expected outputs are queued per cycle.
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid, id_use_rs1, id_use_rs2, id_wr, id_load, id_branch, mem_cond;
   logic [4:0] id_rs1, id_rs2, id_rd;

   logic        f_stall, f_bub, f_fl1, f_fl2, f_fl3;
   logic [1:0]  f_fa, f_fb;
   logic [15:0] f_scnt, f_fcnt;
   logic        n_stall, n_bub, n_fl1, n_fl2, n_fl3;
   logic [1:0]  n_fa, n_fb;
   logic [3:0]  n_scnt, n_fcnt;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic v, wr;
      logic [4:0] rd, rs1, rs2;
      logic u1, u2, ld, br, cond;
   } instr_t;

   // {pc_stall, bubble, flush_if_id, flush_id_ex, flush_ex_mem, fwd_a, fwd_b}
   typedef logic [8:0] exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FORWARD_EN(1'b1), .REG_AW(5), .CNT_W(16)) dut_f (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr), .id_rd(id_rd),
      .id_load(id_load), .id_branch(id_branch), .mem_cond(mem_cond),
      .pc_stall(f_stall), .id_ex_bubble(f_bub), .flush_if_id(f_fl1),
      .flush_id_ex(f_fl2), .flush_ex_mem(f_fl3), .fwd_a(f_fa), .fwd_b(f_fb),
      .stall_cnt(f_scnt), .flush_cnt(f_fcnt));

   pipe_hazard_ctrl #(.FORWARD_EN(1'b0), .REG_AW(5), .CNT_W(4)) dut_n (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_wr(id_wr), .id_rd(id_rd),
      .id_load(id_load), .id_branch(id_branch), .mem_cond(mem_cond),
      .pc_stall(n_stall), .id_ex_bubble(n_bub), .flush_if_id(n_fl1),
      .flush_id_ex(n_fl2), .flush_ex_mem(n_fl3), .fwd_a(n_fa), .fwd_b(n_fb),
      .stall_cnt(n_scnt), .flush_cnt(n_fcnt));

   localparam instr_t NOP = '0;

   function automatic instr_t alu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return '{v:1'b1, wr:1'b1, rd:rd, rs1:rs1, rs2:rs2, u1:1'b1, u2:1'b1,
               ld:1'b0, br:1'b0, cond:1'b0};
   endfunction

   function automatic instr_t lw(input logic [4:0] rd, input logic [4:0] rs1);
      return '{v:1'b1, wr:1'b1, rd:rd, rs1:rs1, rs2:5'd0, u1:1'b1, u2:1'b0,
               ld:1'b1, br:1'b0, cond:1'b0};
   endfunction

   function automatic instr_t br(input logic [4:0] rs1, input logic [4:0] rs2);
      return '{v:1'b1, wr:1'b0, rd:5'd0, rs1:rs1, rs2:rs2, u1:1'b1, u2:1'b1,
               ld:1'b0, br:1'b1, cond:1'b0};
   endfunction

   function automatic instr_t with_cond(input instr_t i);
      instr_t r;
      r = i;
      r.cond = 1'b1;
      return r;
   endfunction

   function automatic exp_t ex(input logic st, input logic fl, input logic [1:0] fa, input logic [1:0] fb);
      return {st, st, fl, fl, fl, fa, fb};
   endfunction

   function automatic exp_t obs(input bit nofwd);
      if (nofwd)
         return {n_stall, n_bub, n_fl1, n_fl2, n_fl3, n_fa, n_fb};
      return {f_stall, f_bub, f_fl1, f_fl2, f_fl3, f_fa, f_fb};
   endfunction

   task automatic drive(input instr_t i);
      id_valid   = i.v;
      id_wr      = i.wr;
      id_rd      = i.rd;
      id_rs1     = i.rs1;
      id_rs2     = i.rs2;
      id_use_rs1 = i.u1;
      id_use_rs2 = i.u2;
      id_load    = i.ld;
      id_branch  = i.br;
      mem_cond   = i.cond;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset;
      reset = 1'b1;
      drive(NOP);
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      exp_t e;
      reset = 1'b1;
      drive(alu(5'd3, 5'd1, 5'd2));
      tick();
      q.push_back('0);
      q.push_back('0);
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (obs(1'b0) !== e) begin n_fail++; $display("FAIL reset_out_f: got %b expected %b", obs(1'b0), e); end
      e = q.pop_front();
      n_chk++;
      if (obs(1'b1) !== e) begin n_fail++; $display("FAIL reset_out_n: got %b expected %b", obs(1'b1), e); end
      n_chk++;
      if ({f_scnt, f_fcnt, n_scnt, n_fcnt} !== 40'd0) begin
         n_fail++; $display("FAIL reset_cnt: got %h %h %h %h expected 0", f_scnt, f_fcnt, n_scnt, n_fcnt);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_forward;
      instr_t s[5];
      exp_t   x[5];
      exp_t   e;
      s = '{alu(5'd3, 5'd1, 5'd2), alu(5'd4, 5'd3, 5'd5), alu(5'd9, 5'd3, 5'd3), NOP, NOP};
      x = '{ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b01, 2'b00),
            ex(0, 0, 2'b10, 2'b10), ex(0, 0, 2'b00, 2'b00)};
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         drive(s[c]);
         q.push_back(x[c]);
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b0) !== e) begin n_fail++; $display("FAIL forward c%0d: got %b expected %b", c, obs(1'b0), e); end
         tick();
      end
      n_chk++;
      if (f_scnt !== 16'd0) begin n_fail++; $display("FAIL forward_stall_cnt: got %0d expected 0", f_scnt); end
   endtask

   task automatic test_load_use;
      instr_t s[5];
      exp_t   x[5];
      exp_t   e;
      s = '{lw(5'd2, 5'd1), alu(5'd6, 5'd2, 5'd2), alu(5'd6, 5'd2, 5'd2), NOP, NOP};
      x = '{ex(0, 0, 2'b00, 2'b00), ex(1, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00),
            ex(0, 0, 2'b10, 2'b10), ex(0, 0, 2'b00, 2'b00)};
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         drive(s[c]);
         q.push_back(x[c]);
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b0) !== e) begin n_fail++; $display("FAIL load_use c%0d: got %b expected %b", c, obs(1'b0), e); end
         tick();
      end
      n_chk++;
      if (f_scnt !== 16'd1) begin n_fail++; $display("FAIL load_use_stall_cnt: got %0d expected 1", f_scnt); end
   endtask

   task automatic test_no_forward;
      instr_t s[6];
      exp_t   x[6];
      exp_t   e;
      s = '{alu(5'd7, 5'd1, 5'd2), alu(5'd8, 5'd7, 5'd1), alu(5'd8, 5'd7, 5'd1),
            alu(5'd8, 5'd7, 5'd1), alu(5'd8, 5'd7, 5'd1), NOP};
      x = '{ex(0, 0, 2'b00, 2'b00), ex(1, 0, 2'b00, 2'b00), ex(1, 0, 2'b00, 2'b00),
            ex(1, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00)};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         drive(s[c]);
         q.push_back(x[c]);
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b1) !== e) begin n_fail++; $display("FAIL no_forward c%0d: got %b expected %b", c, obs(1'b1), e); end
         tick();
      end
      n_chk++;
      if (n_scnt !== 4'd3) begin n_fail++; $display("FAIL no_forward_stall_cnt: got %0d expected 3", n_scnt); end
   endtask

   task automatic test_r0;
      instr_t s[6];
      exp_t   e;
      s = '{alu(5'd0, 5'd1, 5'd2), lw(5'd0, 5'd1), alu(5'd0, 5'd0, 5'd0),
            alu(5'd5, 5'd0, 5'd0), NOP, NOP};
      apply_reset();
      for (int c = 0; c < 6; c++) begin
         drive(s[c]);
         q.push_back(ex(0, 0, 2'b00, 2'b00));
         q.push_back(ex(0, 0, 2'b00, 2'b00));
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b0) !== e) begin n_fail++; $display("FAIL r0_fwd c%0d: got %b expected %b", c, obs(1'b0), e); end
         e = q.pop_front();
         n_chk++;
         if (obs(1'b1) !== e) begin n_fail++; $display("FAIL r0_nofwd c%0d: got %b expected %b", c, obs(1'b1), e); end
         tick();
      end
   endtask

   task automatic test_branch;
      instr_t s[5];
      exp_t   x[5];
      exp_t   e;
      s = '{br(5'd1, 5'd2), lw(5'd10, 5'd1), with_cond(lw(5'd12, 5'd1)),
            alu(5'd13, 5'd12, 5'd10), NOP};
      x = '{ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00), ex(0, 1, 2'b00, 2'b00),
            ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00)};
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         drive(s[c]);
         q.push_back(x[c]);
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b0) !== e) begin n_fail++; $display("FAIL branch c%0d: got %b expected %b", c, obs(1'b0), e); end
         tick();
      end
      n_chk++;
      if (f_fcnt !== 16'd1) begin n_fail++; $display("FAIL branch_flush_cnt: got %0d expected 1", f_fcnt); end
   endtask

   task automatic test_simultaneous;
      instr_t     s[5];
      exp_t       x[5];
      exp_t       e;
      logic [1:0] st;
      s = '{br(5'd1, 5'd2), lw(5'd2, 5'd1), with_cond(alu(5'd6, 5'd2, 5'd2)), NOP, NOP};
      x = '{ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00), ex(0, 1, 2'b00, 2'b00),
            ex(0, 0, 2'b00, 2'b00), ex(0, 0, 2'b00, 2'b00)};
      apply_reset();
      for (int c = 0; c < 5; c++) begin
         drive(s[c]);
         q.push_back(x[c]);
         @(negedge clk);
         e = q.pop_front();
         n_chk++;
         if (obs(1'b0) !== e) begin n_fail++; $display("FAIL simul c%0d: got %b expected %b", c, obs(1'b0), e); end
         st = dut_f.state;
         if (c == 3) begin
            n_chk++;
            if (st !== 2'd2) begin n_fail++; $display("FAIL simul_state_flush: got %0d expected 2", st); end
         end
         if (c == 4) begin
            n_chk++;
            if (st !== 2'd0) begin n_fail++; $display("FAIL simul_state_run: got %0d expected 0", st); end
         end
         tick();
      end
      n_chk++;
      if (f_scnt !== 16'd0 || f_fcnt !== 16'd1) begin
         n_fail++; $display("FAIL simul_cnt: got stall %0d flush %0d expected 0 1", f_scnt, f_fcnt);
      end
   endtask

   task automatic test_reset_mid;
      logic [1:0] st;
      exp_t       e;
      apply_reset();
      drive(alu(5'd7, 5'd1, 5'd2));
      tick();
      drive(alu(5'd8, 5'd7, 5'd1));
      q.push_back(ex(1, 0, 2'b00, 2'b00));
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (obs(1'b1) !== e) begin n_fail++; $display("FAIL reset_mid_pre: got %b expected %b", obs(1'b1), e); end
      tick();
      @(negedge clk);
      st = dut_n.state;
      n_chk++;
      if (st !== 2'd1) begin n_fail++; $display("FAIL reset_mid_hold: got %0d expected 1", st); end
      reset = 1'b1;
      tick();
      q.push_back('0);
      @(negedge clk);
      e = q.pop_front();
      n_chk++;
      if (obs(1'b1) !== e) begin n_fail++; $display("FAIL reset_mid_out: got %b expected %b", obs(1'b1), e); end
      n_chk++;
      if (n_scnt !== 4'd0) begin n_fail++; $display("FAIL reset_mid_cnt: got %0d expected 0", n_scnt); end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_saturation;
      int   n;
      logic s;
      apply_reset();
      for (int k = 0; k <= 6; k++) begin
         drive(alu(5'(k + 1), 5'(k), 5'(k)));
         n = 0;
         do begin
            @(negedge clk);
            s = n_stall;
            tick();
            n++;
         end while (s && n < 8);
         if (n >= 8) begin
            n_chk++;
            n_fail++;
            $display("FAIL sat_timeout k%0d: got stall held %0d cycles expected at most 3", k, n);
         end
         if (k == 4) begin
            n_chk++;
            if (n_scnt !== 4'd12) begin n_fail++; $display("FAIL sat_stall_mid: got %0d expected 12", n_scnt); end
         end
      end
      n_chk++;
      if (n_scnt !== 4'hF) begin n_fail++; $display("FAIL sat_stall_cnt: got %0d expected 15", n_scnt); end
      apply_reset();
      for (int k = 0; k < 17; k++) begin
         drive(br(5'd0, 5'd0));
         tick();
         drive(NOP);
         tick();
         drive(with_cond(NOP));
         tick();
      end
      drive(NOP);
      n_chk++;
      if (n_fcnt !== 4'hF) begin n_fail++; $display("FAIL sat_flush_cnt_n: got %0d expected 15", n_fcnt); end
      n_chk++;
      if (f_fcnt !== 16'd17) begin n_fail++; $display("FAIL sat_flush_cnt_f: got %0d expected 17", f_fcnt); end
   endtask

   initial begin
      reset = 1'b1;
      drive(NOP);
      #1;
      test_reset();
      test_forward();
      test_load_use();
      test_no_forward();
      test_r0();
      test_branch();
      test_simultaneous();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing controller for the 5-stage IF/ID/EX/MEM/WB datapath.
- Keeps a shadow scoreboard of destination registers in EX, MEM and WB.
- Detects RAW and load-use hazards and generates stall, bubble, flush and forwarding-select controls.
- Branches are predicted not-taken; a branch resolved taken in MEM flushes the younger instructions. Saturating performance counters are included.

Parameters:
- FORWARD_EN, 1: 1 = forward EX/MEM and MEM/WB results into EX; 0 = resolve every RAW by stalling.
- REG_AW, 5: register-specifier width.
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on the rising clk edge
- id_valid  in  1  IF/ID holds a real instruction
- id_rs1  in  REG_AW  source 1 of ID instruction
- id_rs2  in  REG_AW  source 2 of ID instruction
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- id_wr  in  1  ID instruction writes a register
- id_rd  in  REG_AW  destination of ID instruction
- id_load  in  1  ID instruction is a load
- id_branch  in  1  ID instruction is a branch or jump
- mem_cond  in  1  EX/MEM Cond latch (branch taken)
- pc_stall  out  1  hold PC and IF/ID
- id_ex_bubble  out  1  load NOP into ID/EX
- flush_if_id  out  1  zero IF/ID
- flush_id_ex  out  1  zero ID/EX
- flush_ex_mem  out  1  zero EX/MEM
- fwd_a  out  2  EX operand A select: 00 regfile, 01 EX/MEM ALU, 10 MEM/WB write-back data
- fwd_b  out  2  EX operand B select, same encoding as fwd_a
- stall_cnt  out  CNT_W  stall cycles
- flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Scoreboard: three entries, EX, MEM and WB. Each entry holds {valid, wr, rd, load, branch, rs1, rs2, use1, use2}.
- Advance on every edge: WB<=MEM, MEM<=EX, EX<=ID fields. On a stall, EX<=bubble (all zero).
- Register 0 never creates a hazard, as source or destination.
- Match(X, r): entry X valid, X.wr set, X.rd==r, r!=0, and the ID instruction uses r.
- Hazard (combinational, from ID fields vs entries):
  - FORWARD_EN=1: stall if Match(EX) with EX.load (load-use), or Match(WB). The WB write lands on the same edge that ID/EX captures, so the ID read is stale.
  - FORWARD_EN=0: stall if Match(EX), Match(MEM) or Match(WB).
- Stall: pc_stall=1 and id_ex_bubble=1 in the same cycle; the ID instruction is held.
- Forwarding, evaluated on the EX entry's rs1/rs2: MEM entry (wr, non-load, rd match) gives 01; else WB entry (wr, rd match) gives 10; else 00. MEM has priority over WB. With FORWARD_EN=0, fwd_a and fwd_b are constant 00.
- Branch: when the MEM entry has branch=1 and mem_cond=1:
  - flush_if_id, flush_id_ex and flush_ex_mem are asserted combinationally that cycle;
  - the EX entry and the incoming ID entry are cleared at the edge (MEM advances to WB normally).
- Priority: flush overrides stall. pc_stall=0 and id_ex_bubble=0 while flushing.
- FSM, held in a state register:
  - RUN: normal; go to HOLD on hazard; go to FLUSH on a taken branch.
  - HOLD: stall asserted; stay while the hazard persists; taken branch goes to FLUSH; otherwise go to RUN.
  - FLUSH: one cycle, entered on the edge after flush signalling; cleared entries guarantee no hazard; go to RUN unconditionally.
- Counters: stall_cnt +1 per cycle with pc_stall=1; flush_cnt +1 per taken-branch event. Both saturate at all-ones and do not wrap.
- Reset (synchronous): scoreboard invalid, FSM=RUN, counters=0. All outputs 0 from the first edge with reset high, including fwd=00. Reset mid-stall drops the stall on that edge.
- Latency: all control outputs are combinational from the current scoreboard and ID inputs. The scoreboard update is 1 cycle.

Test Plan:
- Forwarding: ADD r3 then SUB r4,r3,r5 with FORWARD_EN=1 -> no stall; in SUB's EX cycle fwd_a=01. A third instruction using r3 gets fwd=10.
- Load-use: LW r2 then ADD r6,r2,r2 -> exactly 1 cycle with pc_stall=1 and id_ex_bubble=1, then fwd_a=fwd_b=10. stall_cnt=1.
- No forwarding: FORWARD_EN=0, ADD r7 then OR r8,r7,r1 -> 3 stall cycles; stall_cnt=3; fwd stays 00.
- r0 and taken branch: writes to r0 then reads of r0 -> never stall. A branch reaching MEM with mem_cond=1 -> all three flush_* high for 1 cycle; flush_cnt=1.
- Simultaneous: load-use hazard in ID while a taken branch sits in MEM -> flush only, pc_stall=0; next cycle FSM=FLUSH, no hazard.
- Reset mid-operation: reset during HOLD -> pc_stall=0 on that edge; counters=0. Counter saturation: preload to 0xFFFE, then 3 stalls -> 0xFFFF.
